// File: rtl/game_link_pkg.sv
// Shared definitions for the inter-board game link: frame bytes, message
// types and the receive parser state encoding.
package game_link_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam logic [7:0] TYPE_ENTER     = 8'h01;
    localparam logic [7:0] TYPE_TURN_DONE = 8'h02;
    localparam logic [7:0] TYPE_HP        = 8'h03;

    // SYNC, TYPE, D_HI, D_LO, CHK
    localparam int FRAME_LEN = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_GET_TYPE,
        RX_GET_HI,
        RX_GET_LO,
        RX_GET_CHK
    } rx_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] frame_type,
                                             input logic [7:0] d_hi,
                                             input logic [7:0] d_lo);
        return frame_type ^ d_hi ^ d_lo;
    endfunction

endpackage

// File: rtl/link_timeout_timer.sv
// Inter-byte idle timer: restarts on every received byte, counts while enabled,
// and pulses expire on the last idle cycle of the allowed gap.
module link_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // A byte arriving on the final cycle wins over expiry.
    assign expire = enable && !restart && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || !enable || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_link_rx.sv
// Receive-side frame parser for the game link: turns 5-byte frames from the
// UART into remote-player event pulses and the remote HP register.
module game_link_rx
    import game_link_pkg::*;
#(
    parameter logic [9:0] HP_INIT        = 10'd100,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       enter_pressed_remote,
    output logic       turn_done_remote,
    output logic [9:0] hp_remote,
    output logic       frame_err,
    output logic       link_busy
);

    rx_state_t  state, state_d;
    logic [7:0] type_q, hi_q, lo_q;
    logic       enter_q, enter_d;
    logic       turn_q, turn_d;
    logic       err_q, err_d;
    logic [9:0] hp_q, hp_d;
    logic       expire;
    logic       chk_ok;

    link_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_valid),
        .enable  (state != RX_IDLE),
        .expire  (expire)
    );

    assign chk_ok = (rx_data == frame_chk(type_q, hi_q, lo_q));

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave a signal unassigned and infer a latch.
        state_d = state;
        enter_d = 1'b0;
        turn_d  = 1'b0;
        err_d   = 1'b0;
        hp_d    = hp_q;

        if (rx_valid) begin
            case (state)
                RX_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = RX_GET_TYPE;
                    end
                end
                RX_GET_TYPE: state_d = RX_GET_HI;
                RX_GET_HI:   state_d = RX_GET_LO;
                RX_GET_LO:   state_d = RX_GET_CHK;
                RX_GET_CHK: begin
                    state_d = RX_IDLE;
                    if (!chk_ok) begin
                        err_d = 1'b1;
                    end else begin
                        case (type_q)
                            TYPE_ENTER:     enter_d = 1'b1;
                            TYPE_TURN_DONE: turn_d  = 1'b1;
                            TYPE_HP: begin
                                // Only 10 payload bits exist; stray upper bits mean corruption.
                                if (hi_q[7:2] == 6'd0) begin
                                    hp_d = {hi_q[1:0], lo_q};
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default:        err_d = 1'b1;
                        endcase
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (expire) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            enter_q <= 1'b0;
            turn_q  <= 1'b0;
            err_q   <= 1'b0;
            hp_q    <= HP_INIT;
        end else begin
            state   <= state_d;
            enter_q <= enter_d;
            turn_q  <= turn_d;
            err_q   <= err_d;
            hp_q    <= hp_d;
        end
    end

    // NOTE: the captured frame bytes carry no reset; each is always written
    // earlier in the same frame before GET_CHK reads it.
    always_ff @(posedge clk) begin
        if (rx_valid) begin
            case (state)
                RX_GET_TYPE: type_q <= rx_data;
                RX_GET_HI:   hi_q   <= rx_data;
                RX_GET_LO:   lo_q   <= rx_data;
                default: ;
            endcase
        end
    end

    assign enter_pressed_remote = enter_q;
    assign turn_done_remote     = turn_q;
    assign frame_err            = err_q;
    assign hp_remote            = hp_q;
    assign link_busy            = (state != RX_IDLE);

endmodule

// File: doc/game_link_rx.md
Name: game_link_rx

Overview:
Receive-side decoder for the inter-board game link. It takes a byte stream from the UART receiver and parses fixed 5-byte frames sent by the remote board. It delivers the remote player's events to game_fsm as single-cycle pulses (enter press, turn done) and maintains the remote HP register. It is the counterpart of the link transmitter that serialises the local board's events.

Parameters:
HP_INIT, 10'd100, value loaded into hp_remote at reset; must be nonzero.
TIMEOUT_CYCLES, 1_000_000, maximum idle gap between bytes of one frame before the partial frame is dropped.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid when high
enter_pressed_remote  out  1  one-cycle pulse on a valid ENTER frame
turn_done_remote  out  1  one-cycle pulse on a valid TURN_DONE frame
hp_remote  out  10  last valid HP value received
frame_err  out  1  one-cycle pulse on checksum, type or timeout error
link_busy  out  1  high while a frame is partially received

Behaviour:
- Frame format, in order: SYNC=8'hA5, TYPE, D_HI, D_LO, CHK.
- CHK = TYPE ^ D_HI ^ D_LO.
- TYPE values: 8'h01 ENTER, 8'h02 TURN_DONE, 8'h03 HP.
- HP payload = {D_HI[1:0], D_LO}. D_HI[7:2] must be 0, otherwise the frame is an error.
- ENTER and TURN_DONE ignore the payload but still include it in CHK.
- Reset (asserted asynchronously, released synchronously):
  - state = IDLE, hp_remote = HP_INIT.
  - All pulses, frame_err and link_busy = 0.
  - Timeout counter = 0.
- States: IDLE, GET_TYPE, GET_HI, GET_LO, GET_CHK. State advances only on cycles with rx_valid=1.
  - IDLE: byte == SYNC → GET_TYPE. Any other byte is discarded silently, with no error.
  - GET_TYPE → GET_HI → GET_LO → GET_CHK: each state captures its byte.
  - GET_CHK: the byte is compared with the computed CHK.
    - Match, known type, legal payload: the action fires, then IDLE.
    - Otherwise: frame_err pulse, then IDLE.
- Latency: the output pulse or hp_remote update is registered and appears exactly 1 cycle after the cycle in which the CHK byte is sampled.
- Pulses are exactly 1 cycle wide. Back-to-back frames produce separate pulses.
- Timeout:
  - The counter resets on every rx_valid and counts while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: frame_err pulse, state → IDLE.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- Resync: a SYNC byte received in GET_TYPE is treated as TYPE. There is no mid-frame resync; recovery is by CHK error or timeout.
- hp_remote holds its value between HP frames. An HP frame carrying 0 is legal and drives hp_remote = 0, which game_fsm uses as the game-over trigger.
- link_busy = (state != IDLE).
- rx_valid held high for consecutive cycles is processed one byte per cycle.
- Reset asserted mid-frame: the partial frame is discarded and hp_remote returns to HP_INIT.

Decomposition:
- Shared package game_link_pkg holds:
  - the SYNC byte constant and TYPE constants;
  - the rx state enum (logic [2:0]);
  - the frame length constant.
- The link transmitter imports the same package.
- One sub-module, link_timeout_timer, holds the parameterised counter with restart/enable inputs and an expire pulse output. All parsing stays in game_link_rx.

Test Plan:
- Reset released, no input → hp_remote=100, all pulses 0, link_busy=0 for 100 cycles.
- Frame A5 01 00 00 01 → enter_pressed_remote high for exactly 1 cycle, 1 cycle after the CHK byte; frame_err=0.
- Frame A5 03 00 32 31 → hp_remote=50. Then A5 03 00 00 03 → hp_remote=0. Then A5 03 03 FF FF → hp_remote=1023.
- Frame A5 02 00 00 00 (bad CHK) → frame_err pulse, no turn_done_remote. Following frame A5 02 00 00 02 → turn_done_remote pulse.
- Timeout: send A5 02, then idle TIMEOUT_CYCLES (set to 16) cycles → frame_err pulse at cycle 16, link_busy falls. Repeat with a byte on the expiry cycle → no error.
- Garbage 00 FF 12, then a valid ENTER frame streamed with rx_valid high 5 consecutive cycles → no errors, exactly one enter pulse. HP frame with D_HI=04 → frame_err, hp_remote unchanged.
